bram_write_arbiter: RTL and testbench

//  Shares the single write port (address0/ce0/we0/d0) of a bram2hs-style cast buffer between NUM_REQ producers.

---
 rtl/bram_write_arbiter_if.sv | 34 +++
 rtl/bram_write_arbiter.sv | 177 +++++++++++++++++
 tb/tb_bram_write_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_write_arbiter_if.sv
// Producer-lane write requests, BRAM write port and cast handshake
// shared between the producer side (master) and the arbiter (slave).
interface bram_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7
);
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_last;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [ADDR_WIDTH-1:0]              address0;
  logic                               ce0;
  logic                               we0;
  logic [DATA_WIDTH-1:0]              d0;
  logic                               in_done;
  logic                               cast_busy;
  logic                               addr_err;

  modport master (
    output req_valid, req_last, req_addr, req_data,
    output cast_busy,
    input  req_ready, address0, ce0, we0, d0,
    input  in_done, addr_err
  );

  modport slave (
    input  req_valid, req_last, req_addr, req_data,
    input  cast_busy,
    output req_ready, address0, ce0, we0, d0,
    output in_done, addr_err
  );
endinterface

// File: rtl/bram_write_arbiter.sv
// Shares one BRAM write port between NUM_REQ producers for one batch.
// Define BRAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module bram_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int ADDR_RANGE = 100
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bram_write_arbiter_if.slave  bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_FILL,
    S_FLUSH,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t                r_state;
  state_t                w_state_nx;
  logic [NUM_REQ-1:0]    r_fin;
  logic [NUM_REQ-1:0]    w_fin_nx;
  logic                  r_seen;
  logic                  w_seen_nx;
  logic [NUM_REQ-1:0]    w_elig;
  logic [NUM_REQ-1:0]    w_gnt;
  logic [IW-1:0]         w_win;
  logic                  w_found;
  logic                  w_acc;
  logic                  w_oor;
  logic                  w_in_done;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_sel_last;
  logic [ADDR_WIDTH-1:0] r_addr0;
  logic [DATA_WIDTH-1:0] r_d0;
  logic                  r_ce;
  logic                  r_err;

  assign w_elig = bus.req_valid & ~r_fin;

`ifdef BRAM_ARB_FIXED_PRIO_EN
  // Lowest eligible index wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_elig[k]) begin
        w_found = 1'b1;
        w_win   = IW'(k);
      end
    end
  end
`else
  logic [IW-1:0] r_rr;
  logic [IW-1:0] w_idx;

  // First eligible lane searching upward from the rr pointer.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = IW'((32'(r_rr) + 32'(k)) % 32'(NUM_REQ));
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Pointer moves just past the winner; idle cycles leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr <= '0;
    end else if (w_acc) begin
      if (32'(w_win) == NUM_REQ - 1) r_rr <= '0;
      else                           r_rr <= w_win + 1'b1;
    end
  end
`endif

  // One-hot grant, only while filling and out of reset.
  always_comb begin
    w_gnt = '0;
    if (w_found && (r_state == S_FILL) && rst_n)
      w_gnt[w_win] = 1'b1;
  end

  assign w_acc      = |w_gnt;
  assign w_sel_addr = bus.req_addr[w_win];
  assign w_sel_data = bus.req_data[w_win];
  assign w_sel_last = bus.req_last[w_win];
  assign w_oor      = 32'(w_sel_addr) >= ADDR_RANGE;

  // Batch sequencing: next state, finished mask, busy-seen flag.
  always_comb begin
    w_state_nx = r_state;
    w_fin_nx   = r_fin;
    w_seen_nx  = r_seen;
    w_in_done  = 1'b0;
    unique case (r_state)
      S_FILL: begin
        if (w_acc && w_sel_last)
          w_fin_nx = r_fin | w_gnt;
        if (&w_fin_nx)
          w_state_nx = S_FLUSH;
      end
      S_FLUSH: begin
        w_state_nx = S_DONE;
      end
      S_DONE: begin
        if (!bus.cast_busy) begin
          w_in_done  = 1'b1;
          w_state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.cast_busy)
          w_seen_nx = 1'b1;
        if (r_seen && !bus.cast_busy) begin
          w_seen_nx  = 1'b0;
          w_fin_nx   = '0;
          w_state_nx = S_FILL;
        end
      end
      default: begin
        w_state_nx = S_FILL;
      end
    endcase
  end

  // State, finished mask and busy-seen registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FILL;
      r_fin   <= '0;
      r_seen  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_fin   <= w_fin_nx;
      r_seen  <= w_seen_nx;
    end
  end

  // Registered BRAM port; out-of-range writes are dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr0 <= '0;
      r_d0    <= '0;
      r_ce    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ce <= 1'b0;
      if (w_acc) begin
        r_addr0 <= w_sel_addr;
        r_d0    <= w_sel_data;
        r_ce    <= !w_oor;
        if (w_oor)
          r_err <= 1'b1;
      end
    end
  end

  assign bus.req_ready = w_gnt;
  assign bus.address0  = r_addr0;
  assign bus.ce0       = r_ce;
  assign bus.we0       = r_ce;
  assign bus.d0        = r_d0;
  assign bus.in_done   = w_in_done;
  assign bus.addr_err  = r_err;

endmodule

// File: tb/tb_bram_write_arbiter.sv
// Directed bench for bram_write_arbiter.
// Fixed-priority scenario runs when BRAM_ARB_FIXED_PRIO_EN is defined.
module tb_bram_write_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int AW = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bram_write_arbiter_if #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) bus ();

  bram_write_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW), .ADDR_RANGE(100)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  logic [DW-1:0] mem [0:127];
  always @(posedge clk)
    if (bus.ce0 && bus.we0) mem[bus.address0] <= bus.d0;

  int n_pass = 0;
  int n_tot  = 0;
  int pulses = 0;
  int cnt [4];
  int w;
  logic [3:0] v;
  logic [3:0] l;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setl(input int i, input int a, input int d);
    bus.req_addr[i] = AW'(a);
    bus.req_data[i] = DW'(d);
  endtask

  task automatic acc(input string tag, input logic [3:0] vv,
                     input logic [3:0] ll, input logic [3:0] er);
    bus.req_valid = vv;
    bus.req_last  = ll;
    #1;
    chk({tag, "_rdy"}, 32'(bus.req_ready), 32'(er));
    tick();
  endtask

  task automatic wr(input string tag, input int a, input int d);
    chk({tag, "_ce"}, 32'(bus.ce0), 1);
    chk({tag, "_we"}, 32'(bus.we0), 1);
    chk({tag, "_a"}, 32'(bus.address0), 32'(a));
    chk({tag, "_d"}, 32'(bus.d0), 32'(d));
  endtask

  task automatic drain(input string tag);
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b1111;
    #1;
    chk({tag, "_dr0"}, 32'(bus.req_ready), 0);
    bus.cast_busy = 1'b1;
    tick();
    chk({tag, "_dr1"}, 32'(bus.req_ready), 0);
    bus.cast_busy = 1'b0;
    #1;
    chk({tag, "_dr2"}, 32'(bus.req_ready), 0);
    bus.req_valid = 4'b0000;
    bus.req_last  = 4'b0000;
    tick();
  endtask

  task automatic end_batch(input string tag);
    bus.req_valid = 4'b0000;
    bus.req_last  = 4'b0000;
    chk({tag, "_flush_done"}, 32'(bus.in_done), 0);
    tick();
    chk({tag, "_done"}, 32'(bus.in_done), 1);
    chk({tag, "_done_ce"}, 32'(bus.ce0), 0);
    tick();
    chk({tag, "_done_off"}, 32'(bus.in_done), 0);
    drain(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b0000;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.cast_busy = 1'b0;
    #2;
    chk("rst_rdy", 32'(bus.req_ready), 0);
    chk("rst_ce", 32'(bus.ce0), 0);
    chk("rst_we", 32'(bus.we0), 0);
    chk("rst_a", 32'(bus.address0), 0);
    chk("rst_d", 32'(bus.d0), 0);
    chk("rst_done", 32'(bus.in_done), 0);
    chk("rst_err", 32'(bus.addr_err), 0);
    bus.req_valid = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;

`ifndef BRAM_ARB_FIXED_PRIO_EN
    // 1: two words per lane, all valid, round-robin 0,1,2,3,0,1,2,3
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int c = 0; c < 8; c++) begin
      w = c % 4;
      for (int i = 0; i < 4; i++) begin
        setl(i, i * 2 + cnt[i], 'h40 + i * 2 + cnt[i]);
        v[i] = cnt[i] < 2;
        l[i] = cnt[i] == 1;
      end
      acc("t1", v, l, 4'(1 << w));
      cnt[w]++;
      wr("t1", w * 2 + c / 4, 'h40 + w * 2 + c / 4);
      pulses += 32'(bus.ce0);
    end
    chk("t1_pulses", 32'(pulses), 8);
    end_batch("t1");

    // 2: lanes 0,1,3 finish at addr 0, lane 2 back-to-back 5,6,7
    for (int i = 0; i < 4; i++) setl(i, 0, 0);
    acc("t2a", 4'b1011, 4'b1011, 4'b0001);
    acc("t2b", 4'b1011, 4'b1011, 4'b0010);
    acc("t2c", 4'b1011, 4'b1011, 4'b1000);
    setl(2, 5, 'h55);
    acc("t2_5", 4'b1111, 4'b1011, 4'b0100);
    wr("t2_5", 5, 'h55);
    setl(2, 6, 'h66);
    acc("t2_6", 4'b1111, 4'b1011, 4'b0100);
    wr("t2_6", 6, 'h66);
    setl(2, 7, 'h77);
    acc("t2_7", 4'b1111, 4'b1111, 4'b0100);
    wr("t2_7", 7, 'h77);
    end_batch("t2");
    chk("t2_m5", 32'(mem[5]), 'h55);
    chk("t2_m6", 32'(mem[6]), 'h66);
    chk("t2_m7", 32'(mem[7]), 'h77);

    // 3: lane 0 writes addr 100 (dropped), lane 1 writes 99
    setl(0, 100, 'hC0);
    setl(1, 99, 'hC1);
    setl(2, 22, 'hC2);
    setl(3, 23, 'hC3);
    acc("t3_3", 4'b1111, 4'b1111, 4'b1000);
    wr("t3_3", 23, 'hC3);
    chk("t3_err0", 32'(bus.addr_err), 0);
    acc("t3_0", 4'b1111, 4'b1111, 4'b0001);
    chk("t3_0_ce", 32'(bus.ce0), 0);
    chk("t3_0_we", 32'(bus.we0), 0);
    chk("t3_err1", 32'(bus.addr_err), 1);
    acc("t3_1", 4'b1111, 4'b1111, 4'b0010);
    wr("t3_1", 99, 'hC1);
    acc("t3_2", 4'b1111, 4'b1111, 4'b0100);
    wr("t3_2", 22, 'hC2);
    chk("t3_err2", 32'(bus.addr_err), 1);
    end_batch("t3");
    chk("t3_m99", 32'(mem[99]), 'hC1);
    chk("t3_err3", 32'(bus.addr_err), 1);

    // 4: cast busy at DONE entry for 5 cycles
    for (int i = 0; i < 4; i++) setl(i, 30 + i, 'hD0 + i);
    acc("t4_3", 4'b1111, 4'b1111, 4'b1000);
    acc("t4_0", 4'b1111, 4'b1111, 4'b0001);
    acc("t4_1", 4'b1111, 4'b1111, 4'b0010);
    acc("t4_2", 4'b1111, 4'b1111, 4'b0100);
    wr("t4_2", 32, 'hD2);
    bus.req_valid = 4'b0000;
    bus.req_last  = 4'b0000;
    bus.cast_busy = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold", 32'(bus.in_done), 0);
      tick();
    end
    bus.cast_busy = 1'b0;
    #1;
    chk("t4_pulse", 32'(bus.in_done), 1);
    tick();
    chk("t4_pulse_off", 32'(bus.in_done), 0);
    bus.req_valid = 4'b1111;
    #1;
    chk("t4_drain_a", 32'(bus.req_ready), 0);
    tick();
    chk("t4_drain_b", 32'(bus.req_ready), 0);
    tick();
    drain("t4");

    // 5: three last-writes (lanes 1,2,3) then async reset
    for (int i = 0; i < 4; i++) setl(i, 40 + i, 'hE0 + i);
    acc("t5_fill", 4'b0010, 4'b0010, 4'b0010);
    wr("t5_fill", 41, 'hE1);
    acc("t5_w2", 4'b1100, 4'b1100, 4'b0100);
    acc("t5_w3", 4'b1100, 4'b1100, 4'b1000);
    wr("t5_w3", 43, 'hE3);
    chk("t5_err_pre", 32'(bus.addr_err), 1);
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b0000;
    rst_n = 1'b0;
    #1;
    chk("t5_rdy", 32'(bus.req_ready), 0);
    chk("t5_ce", 32'(bus.ce0), 0);
    chk("t5_we", 32'(bus.we0), 0);
    chk("t5_a", 32'(bus.address0), 0);
    chk("t5_d", 32'(bus.d0), 0);
    chk("t5_err", 32'(bus.addr_err), 0);
    chk("t5_done", 32'(bus.in_done), 0);
    tick();
    rst_n = 1'b1;
    acc("t5_g0", 4'b1111, 4'b0000, 4'b0001);
    wr("t5_g0", 40, 'hE0);
    acc("t5_g1", 4'b1111, 4'b0000, 4'b0010);
    acc("t5_g2", 4'b1111, 4'b0000, 4'b0100);
    acc("t5_g3", 4'b1111, 4'b0000, 4'b1000);
    wr("t5_g3", 43, 'hE3);
`else
    // 6: lanes 0 and 3 always valid, lane 0 wins until its last
    setl(0, 50, 'hA0);
    setl(3, 60, 'hB0);
    acc("t6_a", 4'b1001, 4'b0000, 4'b0001);
    wr("t6_a", 50, 'hA0);
    setl(0, 51, 'hA1);
    acc("t6_b", 4'b1001, 4'b0000, 4'b0001);
    wr("t6_b", 51, 'hA1);
    setl(0, 52, 'hA2);
    acc("t6_c", 4'b1001, 4'b0001, 4'b0001);
    wr("t6_c", 52, 'hA2);
    acc("t6_d", 4'b1001, 4'b0001, 4'b1000);
    wr("t6_d", 60, 'hB0);
    setl(3, 61, 'hB1);
    acc("t6_e", 4'b1001, 4'b1001, 4'b1000);
    wr("t6_e", 61, 'hB1);
    end_batch("t6");
    chk("t6_m52", 32'(mem[52]), 'hA2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
